// File: rtl/pw_pool_scheduler.sv
// pw_pool_scheduler: sequences the pointwise-conv -> ping-pong buffer -> pool path.
// For each column it sweeps output-channel groups (outer) and input-channel
// groups (inner), flushes the select delay line, and after every odd column
// (banks A and B both full) runs one pool read sweep.
// Optional build macro: PW_POOL_SCHED_PERF_CNT_EN adds the busy_cycles counter.
module pw_pool_scheduler #(
   parameter int SEL_DELAY = 3,
   parameter int GRP_STEP  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  layer_in,
   input  logic [7:0]  num_oc_grp,
   input  logic [7:0]  num_ic_grp,
   output logic [3:0]  layer,
   output logic [7:0]  col,
   output logic        point_doing,
   output logic [7:0]  point_output_channel_sel,
   output logic [7:0]  point_input_channel_sel,
   output logic [7:0]  point_output_channel_sel_delay3,
   output logic [7:0]  point_input_channel_sel_delay3,
   output logic        point11_done,
   output logic        pool_doing,
   output logic [7:0]  pool_channel_sel,
   output logic        layer_done
`ifdef PW_POOL_SCHED_PERF_CNT_EN
   ,
   output logic [31:0] busy_cycles
`endif
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      POINT = 3'd1,
      DRAIN = 3'd2,
      POOL  = 3'd3,
      NEXT  = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [3:0]  r_layer;
   logic [7:0]  r_noc;
   logic [7:0]  r_nic;
   logic [7:0]  r_col;
   logic [7:0]  r_oc;
   logic [7:0]  r_ic;
   logic [7:0]  r_cnt;     // DRAIN wait counter, then pool read address

   logic [7:0]  r_oc_dly   [SEL_DELAY];
   logic [7:0]  r_ic_dly   [SEL_DELAY];
   logic        r_last_dly [SEL_DELAY];

   logic [7:0]  w_col_end;
   logic        w_last_pair;
   logic        w_drain_end;
   logic        w_pool_end;
   logic [7:0]  w_oc_sel;
   logic [7:0]  w_ic_sel;

   // Column count depends on the layer's spatial size; always odd so columns pair into banks.
   assign w_col_end   = (r_layer < 4'd4) ? 8'd15 : ((r_layer < 4'd8) ? 8'd7 : 8'd3);
   assign w_last_pair = (r_state == POINT) && (r_oc == r_noc - 8'd1) && (r_ic == r_nic - 8'd1);
   assign w_drain_end = (r_cnt == 8'(SEL_DELAY));
   assign w_pool_end  = (r_cnt == r_noc);

   // Next-state and output decode.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      w_next                   = r_state;
      point_doing              = 1'b0;
      w_oc_sel                 = 8'd0;
      w_ic_sel                 = 8'd0;
      pool_doing               = 1'b0;
      pool_channel_sel         = 8'd0;
      layer_done               = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) w_next = POINT;
         end
         POINT: begin
            point_doing = 1'b1;
            w_oc_sel    = 8'(r_oc * GRP_STEP);
            w_ic_sel    = 8'(r_ic * GRP_STEP);
            if (w_last_pair) w_next = DRAIN;
         end
         DRAIN: begin
            // The extra cycle past point11_done covers the buffer's bank toggle.
            if (w_drain_end) w_next = r_col[0] ? POOL : NEXT;
         end
         POOL: begin
            // Final POOL cycle has pool_doing low: it covers the registered read.
            if (w_pool_end) begin
               w_next = NEXT;
            end else begin
               pool_doing       = 1'b1;
               pool_channel_sel = 8'(r_cnt * GRP_STEP);
            end
         end
         NEXT: begin
            if (r_col == w_col_end) begin
               layer_done = 1'b1;
               w_next     = IDLE;
            end else begin
               w_next = POINT;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   assign point_output_channel_sel        = w_oc_sel;
   assign point_input_channel_sel         = w_ic_sel;
   assign point_output_channel_sel_delay3 = r_oc_dly[SEL_DELAY-1];
   assign point_input_channel_sel_delay3  = r_ic_dly[SEL_DELAY-1];
   assign point11_done                    = r_last_dly[SEL_DELAY-1];
   assign layer                           = r_layer;
   assign col                             = r_col;

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Config latch, column / group / wait counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_layer <= 4'd0;
         r_noc   <= 8'd1;
         r_nic   <= 8'd1;
         r_col   <= 8'd0;
         r_oc    <= 8'd0;
         r_ic    <= 8'd0;
         r_cnt   <= 8'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_layer <= layer_in;
                  r_noc   <= (num_oc_grp == 8'd0) ? 8'd1 : num_oc_grp;
                  r_nic   <= (num_ic_grp == 8'd0) ? 8'd1 : num_ic_grp;
                  r_col   <= 8'd0;
                  r_oc    <= 8'd0;
                  r_ic    <= 8'd0;
                  r_cnt   <= 8'd0;
               end
            end
            POINT: begin
               if (w_last_pair) begin
                  r_oc  <= 8'd0;
                  r_ic  <= 8'd0;
                  r_cnt <= 8'd0;
               end else if (r_ic == r_nic - 8'd1) begin
                  r_ic <= 8'd0;
                  r_oc <= r_oc + 8'd1;
               end else begin
                  r_ic <= r_ic + 8'd1;
               end
            end
            DRAIN: begin
               r_cnt <= w_drain_end ? 8'd0 : r_cnt + 8'd1;
            end
            POOL: begin
               r_cnt <= w_pool_end ? 8'd0 : r_cnt + 8'd1;
            end
            NEXT: begin
               if (r_col != w_col_end) r_col <= r_col + 8'd1;
            end
            default: ;
         endcase
      end
   end

   // Select delay lines; they shift every cycle regardless of state.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: this small shift register is reset (unlike a RAM) because its last stage drives outputs.
         for (int i = 0; i < SEL_DELAY; i++) begin
            r_oc_dly[i]   <= 8'd0;
            r_ic_dly[i]   <= 8'd0;
            r_last_dly[i] <= 1'b0;
         end
      end else begin
         r_oc_dly[0]   <= w_oc_sel;
         r_ic_dly[0]   <= w_ic_sel;
         r_last_dly[0] <= w_last_pair;
         for (int i = 1; i < SEL_DELAY; i++) begin
            r_oc_dly[i]   <= r_oc_dly[i-1];
            r_ic_dly[i]   <= r_ic_dly[i-1];
            r_last_dly[i] <= r_last_dly[i-1];
         end
      end
   end

`ifdef PW_POOL_SCHED_PERF_CNT_EN
   logic [31:0] r_busy;

   // Saturating count of non-IDLE cycles, cleared by an accepted start.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= 32'd0;
      end else if (r_state == IDLE) begin
         if (start) r_busy <= 32'd0;
      end else if (r_busy != 32'hFFFF_FFFF) begin
         r_busy <= r_busy + 32'd1;
      end
   end

   assign busy_cycles = r_busy;
`endif

endmodule

// File: tb/tb_pw_pool_scheduler.sv
// tb_pw_pool_scheduler: directed self-checking bench for pw_pool_scheduler.
// Build with PW_POOL_SCHED_PERF_CNT_EN defined to also check busy_cycles.
module tb_pw_pool_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  layer_in;
   logic [7:0]  num_oc_grp;
   logic [7:0]  num_ic_grp;
   logic [3:0]  layer;
   logic [7:0]  col;
   logic        point_doing;
   logic [7:0]  point_output_channel_sel;
   logic [7:0]  point_input_channel_sel;
   logic [7:0]  point_output_channel_sel_delay3;
   logic [7:0]  point_input_channel_sel_delay3;
   logic        point11_done;
   logic        pool_doing;
   logic [7:0]  pool_channel_sel;
   logic        layer_done;
`ifdef PW_POOL_SCHED_PERF_CNT_EN
   logic [31:0] busy_cycles;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   // Per-cycle capture for the first run (index = cycles after the start edge).
   int a_osel [61];
   int a_isel [61];
   int a_od3  [61];
   int a_id3  [61];
   int a_p11  [61];
   int a_pd   [61];
   int a_pool [61];
   int a_psel [61];
   int a_ld   [61];
   int a_col  [61];
   int a_layer[61];

   pw_pool_scheduler dut (
      .clk                             (clk),
      .rst                             (rst),
      .start                           (start),
      .layer_in                        (layer_in),
      .num_oc_grp                      (num_oc_grp),
      .num_ic_grp                      (num_ic_grp),
      .layer                           (layer),
      .col                             (col),
      .point_doing                     (point_doing),
      .point_output_channel_sel        (point_output_channel_sel),
      .point_input_channel_sel         (point_input_channel_sel),
      .point_output_channel_sel_delay3 (point_output_channel_sel_delay3),
      .point_input_channel_sel_delay3  (point_input_channel_sel_delay3),
      .point11_done                    (point11_done),
      .pool_doing                      (pool_doing),
      .pool_channel_sel                (pool_channel_sel),
      .layer_done                      (layer_done)
`ifdef PW_POOL_SCHED_PERF_CNT_EN
      ,
      .busy_cycles                     (busy_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Advance one clock and settle away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic start_layer(input logic [3:0] l, input logic [7:0] noc, input logic [7:0] nic);
      layer_in   = l;
      num_oc_grp = noc;
      num_ic_grp = nic;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   initial begin : stim
      int exp_osel [6];
      int exp_isel [6];
      int cnt_p11, cnt_pd, cnt_pool, cnt_ld, cnt_ovl, cnt_sweep, ld_at, prev_pool, sel_bad;

      exp_osel = '{0, 0, 0, 8, 8, 8};
      exp_isel = '{0, 8, 16, 0, 8, 16};

      rst        = 1'b1;
      start      = 1'b0;
      layer_in   = 4'd0;
      num_oc_grp = 8'd0;
      num_ic_grp = 8'd0;
      tick();
      tick();

      // Reset state.
      check("rst_point_doing", point_doing, 0);
      check("rst_pool_doing",  pool_doing,  0);
      check("rst_col",         col,         0);
      check("rst_layer",       layer,       0);
      check("rst_od3",         point_output_channel_sel_delay3, 0);
      check("rst_layer_done",  layer_done,  0);
      rst = 1'b0;
      tick();

      // Test 1/2/6: layer 8 (col_end 3), 2 oc groups x 3 ic groups; a stray
      // start with another layer arrives during POINT and must be ignored.
      start_layer(4'd8, 8'd2, 8'd3);
      for (int k = 1; k <= 60; k++) begin
         a_osel[k]  = point_output_channel_sel;
         a_isel[k]  = point_input_channel_sel;
         a_od3[k]   = point_output_channel_sel_delay3;
         a_id3[k]   = point_input_channel_sel_delay3;
         a_p11[k]   = point11_done;
         a_pd[k]    = point_doing;
         a_pool[k]  = pool_doing;
         a_psel[k]  = pool_channel_sel;
         a_ld[k]    = layer_done;
         a_col[k]   = col;
         a_layer[k] = layer;
         if (k == 2) begin
            start      = 1'b1;
            layer_in   = 4'd2;
            num_oc_grp = 8'd5;
            num_ic_grp = 8'd5;
         end else begin
            start = 1'b0;
         end
         tick();
      end

      for (int i = 0; i < 6; i++) begin
         check($sformatf("t1_osel_k%0d", i + 1), a_osel[i + 1], exp_osel[i]);
         check($sformatf("t1_isel_k%0d", i + 1), a_isel[i + 1], exp_isel[i]);
         check($sformatf("t1_od3_k%0d",  i + 4), a_od3[i + 4],  exp_osel[i]);
         check($sformatf("t1_id3_k%0d",  i + 4), a_id3[i + 4],  exp_isel[i]);
      end
      check("t1_point_doing_k6", a_pd[6], 1);
      check("t1_point_doing_k7", a_pd[7], 0);
      check("t1_p11_k9",         a_p11[9], 1);
      cnt_p11 = 0; cnt_pool = 0; cnt_ld = 0;
      for (int k = 1; k <= 11; k++) cnt_p11 += a_p11[k];
      check("t1_p11_col0_count", cnt_p11, 1);
      cnt_p11 = 0;
      for (int k = 1; k <= 60; k++) begin
         cnt_p11  += a_p11[k];
         cnt_pool += a_pool[k];
         cnt_ld   += a_ld[k];
      end
      check("t1_p11_total",  cnt_p11, 4);
      check("t1_pool_total", cnt_pool, 4);
      check("t1_ld_total",   cnt_ld, 1);
      check("t1_pool_k22",   a_pool[22], 1);
      check("t1_psel_k22",   a_psel[22], 0);
      check("t1_pool_k23",   a_pool[23], 1);
      check("t1_psel_k23",   a_psel[23], 8);
      check("t1_pool_k24",   a_pool[24], 0);
      cnt_pool = 0;
      for (int k = 1; k <= 21; k++)  cnt_pool += a_pool[k];
      for (int k = 26; k <= 46; k++) cnt_pool += a_pool[k];
      check("t1_no_pool_even_cols", cnt_pool, 0);
      check("t1_col_k11", a_col[11], 0);
      check("t1_col_k12", a_col[12], 1);
      check("t1_col_k26", a_col[26], 2);
      check("t1_col_k37", a_col[37], 3);
      check("t1_osel_k40", a_osel[40], 8);
      check("t1_layer_k40", a_layer[40], 8);
      check("t1_ld_k50", a_ld[50], 1);
      check("t1_pd_k51", a_pd[51], 0);
`ifdef PW_POOL_SCHED_PERF_CNT_EN
      // Non-IDLE cycles: 2 even cols * 11 + 2 odd cols * 14 = 50.
      check("t6_busy_cycles", busy_cycles, 50);
`endif

      // Test 3: layer 2 (16 cols), 1x1 groups.
      start_layer(4'd2, 8'd1, 8'd1);
      cnt_pd = 0; cnt_ld = 0; cnt_ovl = 0; cnt_sweep = 0; ld_at = -1; prev_pool = 0;
      for (int k = 1; k <= 150; k++) begin
         cnt_pd  += int'(point_doing);
         cnt_ld  += int'(layer_done);
         cnt_ovl += int'(point_doing && pool_doing);
         if (pool_doing && prev_pool == 0) cnt_sweep++;
         prev_pool = int'(pool_doing);
         if (layer_done) ld_at = k;
         tick();
      end
      check("t3_point_cycles", cnt_pd, 16);
      check("t3_pool_sweeps",  cnt_sweep, 8);
      check("t3_ld_count",     cnt_ld, 1);
      check("t3_ld_cycle",     ld_at, 112);
      check("t3_overlap",      cnt_ovl, 0);

      // Test 4: zero group counts behave as 1x1; layer 9 gives 4 columns.
      start_layer(4'd9, 8'd0, 8'd0);
      cnt_pd = 0; cnt_p11 = 0; cnt_pool = 0; ld_at = -1; sel_bad = 0;
      for (int k = 1; k <= 40; k++) begin
         cnt_pd   += int'(point_doing);
         cnt_p11  += int'(point11_done);
         cnt_pool += int'(pool_doing);
         if (point_output_channel_sel != 8'd0 || point_input_channel_sel != 8'd0) sel_bad++;
         if (layer_done) ld_at = k;
         tick();
      end
      check("t4_point_cycles", cnt_pd, 4);
      check("t4_p11_count",    cnt_p11, 4);
      check("t4_pool_cycles",  cnt_pool, 2);
      check("t4_sel_nonzero",  sel_bad, 0);
      check("t4_ld_cycle",     ld_at, 28);

      // Test 5: reset during the col 1 pool sweep, with start asserted too.
      start_layer(4'd8, 8'd2, 8'd3);
      for (int k = 1; k < 22; k++) tick();
      check("t5_in_pool", pool_doing, 1);
      check("t5_col1",    col, 1);
      rst   = 1'b1;
      start = 1'b1;
      tick();
      check("t5_rst_pool_doing",  pool_doing,  0);
      check("t5_rst_point_doing", point_doing, 0);
      check("t5_rst_col",         col,         0);
      check("t5_rst_layer",       layer,       0);
      check("t5_rst_psel",        pool_channel_sel, 0);
      check("t5_rst_id3",         point_input_channel_sel_delay3, 0);
      check("t5_rst_p11",         point11_done, 0);
      check("t5_rst_ld",          layer_done,  0);
      rst   = 1'b0;
      start = 1'b0;
      cnt_ld = 0; cnt_pd = 0;
      for (int k = 0; k < 20; k++) begin
         cnt_ld += int'(layer_done);
         cnt_pd += int'(point_doing);
         tick();
      end
      check("t5_idle_no_ld", cnt_ld, 0);
      check("t5_idle_no_pd", cnt_pd, 0);
      start_layer(4'd8, 8'd2, 8'd3);
      check("t5_restart_col",   col, 0);
      check("t5_restart_pd",    point_doing, 1);
      check("t5_restart_layer", layer, 8);
      tick();
      check("t5_restart_isel_k2", point_input_channel_sel, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pw_pool_scheduler.md
Name: pw_pool_scheduler

Overview:
Sequencer for the pointwise-conv → ping-pong intermediate buffer → pool path.
- Per column, sweeps output-channel groups (outer loop) and input-channel groups (inner loop) to drive the pointwise engine.
- Emits the 3-cycle-delayed channel selects and the `point11_done` pulse that the intermediate buffer consumes.
- After every second column (banks A and B both full), runs one pool read sweep.
- Sits between the layer controller (start/done) and the pointwise, buffer and pool datapaths.

Parameters:
- SEL_DELAY, 3: pipeline delay from issued selects to `*_delay3` outputs.
- GRP_STEP, 8: channel-select increment per group (channels per group).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse: begin layer; ignored unless IDLE
- layer_in  in  4  layer index, latched at start
- num_oc_grp  in  8  output-channel groups per column, latched at start; 0 treated as 1
- num_ic_grp  in  8  input-channel groups per output group, latched at start; 0 treated as 1
- layer  out  4  latched layer index
- col  out  8  current column, 0..col_end
- point_doing  out  1  high while selects are being issued
- point_output_channel_sel  out  8  oc_grp*GRP_STEP
- point_input_channel_sel  out  8  ic_grp*GRP_STEP
- point_output_channel_sel_delay3  out  8  `point_output_channel_sel` delayed SEL_DELAY cycles
- point_input_channel_sel_delay3  out  8  `point_input_channel_sel` delayed SEL_DELAY cycles
- point11_done  out  1  one-cycle pulse aligned with the last delayed select of a column
- pool_doing  out  1  high during the pool sweep
- pool_channel_sel  out  8  pool read address × GRP_STEP
- layer_done  out  1  one-cycle pulse after the final column is pooled

Behaviour:
- Reset: all outputs 0; state IDLE; delay lines cleared.
- Reset mid-operation returns to IDLE next cycle. No `layer_done` is emitted.
- col_end: 15 if layer<4; 7 if layer<8; else 3. Always odd, so columns pair into bank A (even col) and bank B (odd col).

FSM states: IDLE, POINT, DRAIN, POOL, NEXT.

IDLE
- On `start`: latch `layer_in`, `num_oc_grp` and `num_ic_grp`; col=0; go to POINT on the next cycle.

POINT
- `point_doing`=1.
- Each cycle issue (oc,ic), then advance ic. On ic wrap, reset ic to 0 and advance oc.
- The last pair (NOC-1, NIC-1) is issued, then go to DRAIN.
- Column length is exactly NOC*NIC cycles.

DRAIN
- `point_doing`=0; `sel` outputs hold 0.
- Wait SEL_DELAY cycles so the delayed selects flush.
- `point11_done` fires in the cycle the delayed select equals (NOC-1, NIC-1), i.e. SEL_DELAY cycles after that pair was issued.
- One cycle after `point11_done`, go to POOL if col is odd, else NEXT.
- This extra cycle covers the buffer's write-done/bank-toggle latency.

POOL
- `pool_doing`=1.
- `pool_channel_sel` = 0, 8, …, (NOC-1)*8, one per cycle.
- One cycle after the last address, drop `pool_doing`, then go to NEXT. The extra cycle covers the registered read.

NEXT
- If col==col_end: pulse `layer_done` and go to IDLE.
- Else: col++ and go to POINT.
- POINT never starts while POOL is active; this protects bank A from overwrite.

Other rules:
- Selects are 8-bit. The product group*GRP_STEP must be ≤255; otherwise the result is truncated to 8 bits and the behaviour is undefined.
- `start` while not IDLE is ignored; latched config is unchanged.
- `start` and `rst` in the same cycle: `rst` wins.
- Delay lines advance every cycle regardless of state.

Optional Feature:
- Macro: PW_POOL_SCHED_PERF_CNT_EN.
- When defined, adds output port `busy_cycles`, 32 bits:
  - Clears on `start`.
  - Increments each cycle the FSM is not IDLE.
  - Saturates at 0xFFFFFFFF.
  - Holds its value after `layer_done`.
  - Reset to 0.
- When not defined, the port and counter are absent; all other behaviour is identical.

Test Plan:
1. layer_in=8, num_oc_grp=2, num_ic_grp=3, start.
   - POINT issues (0,0) (0,8) (0,16) (8,0) (8,8) (8,16) over 6 cycles.
   - delay3 outputs follow the same sequence 3 cycles later.
   - `point11_done` is a single pulse with (8,16).
   - col runs 0..3 (col_end=3).
2. Same config, col=1 completes.
   - POOL emits `pool_channel_sel` 0 then 8 with `pool_doing`=1.
   - No POOL after cols 0 and 2.
   - `layer_done` fires once after the col=3 pool sweep.
3. layer_in=2, num_oc_grp=1, num_ic_grp=1.
   - 16 columns, 8 pool sweeps.
   - `layer_done` is a single pulse.
   - `point_doing` and `pool_doing` are never high in the same cycle.
4. num_oc_grp=0, num_ic_grp=0 → behaves as 1,1: a single select (0,0) per column.
5. Assert `rst` during POOL of col=1 → next cycle all outputs 0, state IDLE, no `layer_done`. A new `start` restarts at col=0.
6. `start` pulsed while in POINT with different `layer_in` → ignored; col_end and select sequence unchanged. With PW_POOL_SCHED_PERF_CNT_EN, `busy_cycles` at `layer_done` equals the total non-IDLE cycle count computed from test 1.
